public_private_acc: RTL and testbench
=====================================

# public_private_acc

Consumer end of the public/private multiply stream. It accepts 7-lane partial-product beats (`B_out`, `idx_B`) and accumulates each lane into a coefficient buffer of `DEPTH` entries, modulo 2^6. After a fixed number of beats it streams the finished coefficient vector out one coefficient per cycle. It sits directly downstream of the public/private multiply block.

## Interface
- `DEPTH`, default 784: number of coefficient positions; 7 ≤ `DEPTH` ≤ 1024.
- `BEATS`, default 196: number of accepted beats per frame before the drain starts; 1 ≤ `BEATS` ≤ 65535.
- `clk_in` input, 1 bit: single clock.
- `rst_in` input, 1 bit: reset, asynchronous, active-low.
- `B_valid` input, 1 bit: the producer has a beat.
- `B_out` input, 42 bits: 7 lanes of 6 bits; lane k is bits [6k+5:6k].
- `idx_B` input, 10 bits: position of lane 0.
- `B_ready` output, 1 bit: the block accepts a beat.
- `out_valid` output, 1 bit: the output coefficient is valid.
- `out_ready` input, 1 bit: downstream accepts the output coefficient.
- `out_idx` output, 10 bits: position of the output coefficient.
- `out_coef` output, 6 bits: accumulated coefficient.
- `out_last` output, 1 bit: high with the coefficient at position `DEPTH`-1.
- `err` output, 1 bit: sticky flag for an out-of-range `idx_B`.

## Operation
- States: ACCUM, DRAIN.
- Reset: state ACCUM; buffer all zero; beat counter 0; `out_idx` 0; `err` 0; `B_ready` 1; `out_valid` 0; `out_last` 0; `out_coef` 0.
- A beat is accepted when `B_valid` and `B_ready` are both high.
- ACCUM, on an accepted beat with `idx_B` < `DEPTH`:
  - for each lane k in 0..6: position p = `idx_B` + k;
  - if p ≥ `DEPTH`, then p = p − `DEPTH` and the lane is a wrapped lane;
  - buffer[p] = buffer[p] + contribution, truncated to 6 bits.
  - The 7 positions are always distinct, so all 7 updates happen in the same cycle.
- Accepted beat with `idx_B` ≥ `DEPTH`: the buffer is not changed and `err` is set to 1. The beat still counts toward `BEATS`.
- The beat counter increments on each accepted beat. When the accepted beat is number `BEATS`: the counter is cleared and the state goes to DRAIN on the next cycle.
- DRAIN:
  - `B_ready` = 0;
  - `out_valid` = 1, `out_coef` = buffer[`out_idx`];
  - on `out_valid` and `out_ready`: buffer[`out_idx`] is cleared to 0 and `out_idx` increments.
- The transfer at `out_idx` = `DEPTH`-1: `out_idx` returns to 0 and the state returns to ACCUM. The buffer is then all zero and ready for the next frame.
- `err` is cleared only by reset.

## Timing
- `B_ready` is a registered state decode. It is 1 in every ACCUM cycle, including the cycle that accepts the final beat. It is 0 from the first DRAIN cycle.
- An accumulate takes effect on the buffer one cycle after it is accepted.
- `out_valid` rises one cycle after the final beat is accepted. The first drained coefficient already includes that final beat.
- The drain takes exactly `DEPTH` cycles when `out_ready` is held high.
- When `out_ready` is low, `out_idx` and `out_coef` stay stable.
- `out_last` = `out_valid` and (`out_idx` == `DEPTH`-1).
- `B_ready` returns to 1 in the cycle after the last transfer.
- Asynchronous reset in the middle of a frame or a drain: the partial frame is discarded and every output returns to its reset value immediately.

## Configuration
- `PP_ACC_NEGACYCLIC_EN` defined: a wrapped lane contributes −lane mod 64, giving ring reduction with x^DEPTH = −1. Unwrapped lanes add normally.
- `PP_ACC_NEGACYCLIC_EN` undefined: every lane, wrapped or not, is added (cyclic reduction).

## Structure
- Shared package `pp_mm_pkg` holds:
  - `COEF_W` = 6, `LANES` = 7, `IDX_W` = 10;
  - typedef `coef_t` (logic [`COEF_W`-1:0]);
  - typedef `lanes_t` (array of `LANES` `coef_t`);
  - enum `acc_state_t` {ACCUM, DRAIN}.
- Sub-module `pp_lane_map`: purely combinational. Inputs: `idx_B`, `lanes_t`. Outputs, per lane: the reduced position and the signed/unsigned contribution. It holds the macro-dependent logic.

## Test plan
- `DEPTH`=16, `BEATS`=1; one beat at idx 0 with lanes 1..7 → drain gives coefs 1,2,3,4,5,6,7,0,…,0; `out_last` high at idx 15.
- `DEPTH`=16, `BEATS`=1; beat at idx 12 with every lane 1 → positions 12..15 = 1; positions 0..2 = 63 with the macro, 1 without.
- `BEATS`=2; two beats at idx 0, each with lane0 = 40 → coef[0] = 16 (6-bit wrap); the second frame after the drain starts from zero.
- Beat with `idx_B` = `DEPTH` → `err` = 1; drained buffer all zero; `err` still 1 in the next frame.
- `out_ready` toggled 1,0,0,1 during the drain → `out_idx` and `out_coef` hold during the low cycles; no coefficient is skipped or repeated; `B_ready` stays 0 until the last transfer.
- `rst_in` low in the middle of a drain → `out_valid` = 0 and `B_ready` = 1 immediately; the next frame's results contain no residue from the old frame.

Source files
------------

// File: rtl/pp_mm_pkg.sv
// Shared types and widths for the public/private multiply stream.
package pp_mm_pkg;

    localparam int unsigned COEF_W = 6;
    localparam int unsigned LANES  = 7;
    localparam int unsigned IDX_W  = 10;

    typedef logic [COEF_W-1:0] coef_t;
    typedef coef_t [LANES-1:0] lanes_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef idx_t [LANES-1:0]  lane_idx_t;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } acc_state_t;

endpackage

// File: rtl/pp_lane_map.sv
// Per-lane position reduction and contribution for one beat.
// PP_ACC_NEGACYCLIC_EN: wrapped lanes contribute the negated lane (x^DEPTH = -1).
module pp_lane_map
    import pp_mm_pkg::*;
#(
    parameter int unsigned DEPTH = 784
) (
    input  idx_t      idx_B,
    input  lanes_t    i_lanes,
    output lane_idx_t o_pos,
    output lanes_t    o_contrib
);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IDX_W:0] w_sum;
        logic           w_wrap;

        // One extra bit keeps idx_B + k from overflowing before the compare.
        assign w_sum    = {1'b0, idx_B} + (IDX_W+1)'(k);
        assign w_wrap   = (w_sum >= (IDX_W+1)'(DEPTH));
        assign o_pos[k] = w_wrap ? IDX_W'(w_sum - (IDX_W+1)'(DEPTH)) : IDX_W'(w_sum);
`ifdef PP_ACC_NEGACYCLIC_EN
        assign o_contrib[k] = w_wrap ? coef_t'(COEF_W'(0) - i_lanes[k]) : i_lanes[k];
`else
        assign o_contrib[k] = i_lanes[k];
`endif
    end

endmodule

// File: rtl/public_private_acc.sv
// Accumulates 7-lane partial-product beats into a DEPTH-entry buffer, then drains it.
// PP_ACC_NEGACYCLIC_EN selects negacyclic instead of cyclic reduction (see pp_lane_map).
module public_private_acc
    import pp_mm_pkg::*;
#(
    parameter int unsigned DEPTH = 784,
    parameter int unsigned BEATS = 196
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    B_valid,
    input  logic [LANES*COEF_W-1:0] B_out,
    input  logic [IDX_W-1:0]        idx_B,
    output logic                    B_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_idx,
    output logic [COEF_W-1:0]       out_coef,
    output logic                    out_last,
    output logic                    err
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    acc_state_t       r_state;
    coef_t            r_buf [DEPTH];
    logic [CNT_W-1:0] r_cnt;
    idx_t             r_out_idx;
    logic             r_err;
    logic             r_b_ready;
    logic             r_out_valid;
    logic             r_out_last;
    coef_t            r_out_coef;

    acc_state_t       w_state_nxt;
    coef_t            w_buf_nxt [DEPTH];
    logic [CNT_W-1:0] w_cnt_nxt;
    idx_t             w_idx_nxt;
    logic             w_err_nxt;
    logic             w_out_last_nxt;
    coef_t            w_out_coef_nxt;
    logic             w_idx_ok;
    lanes_t           w_lanes;
    lane_idx_t        w_pos;
    lanes_t           w_contrib;

    assign w_lanes  = B_out;
    assign w_idx_ok = ({1'b0, idx_B} < (IDX_W+1)'(DEPTH));

    pp_lane_map #(
        .DEPTH (DEPTH)
    ) u_lane_map (
        .idx_B     (idx_B),
        .i_lanes   (w_lanes),
        .o_pos     (w_pos),
        .o_contrib (w_contrib)
    );

    // Next state, buffer update, beat counter and drain index.
    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_out_idx;
        w_err_nxt   = r_err;
        case (r_state)
            ACCUM: begin
                if (B_valid && r_b_ready) begin
                    if (w_idx_ok) begin
                        for (int k = 0; k < LANES; k++) begin
                            w_buf_nxt[AW'(w_pos[k])] = r_buf[AW'(w_pos[k])] + w_contrib[k];
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    if (r_cnt == CNT_W'(BEATS - 1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = DRAIN;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (r_out_valid && out_ready) begin
                    w_buf_nxt[AW'(r_out_idx)] = '0;
                    if (r_out_idx == IDX_W'(DEPTH - 1)) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ACCUM;
                    end else begin
                        w_idx_nxt = r_out_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    // Output coefficient is read from the next buffer so the final beat is already included.
    always_comb begin
        w_out_coef_nxt = '0;
        w_out_last_nxt = 1'b0;
        if (w_state_nxt == DRAIN) begin
            w_out_coef_nxt = w_buf_nxt[AW'(w_idx_nxt)];
            w_out_last_nxt = (w_idx_nxt == IDX_W'(DEPTH - 1));
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= ACCUM;
            r_buf       <= '{default: '0};
            r_cnt       <= '0;
            r_out_idx   <= '0;
            r_err       <= 1'b0;
            r_b_ready   <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_coef  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf       <= w_buf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_idx   <= w_idx_nxt;
            r_err       <= w_err_nxt;
            r_b_ready   <= (w_state_nxt == ACCUM);
            r_out_valid <= (w_state_nxt == DRAIN);
            r_out_last  <= w_out_last_nxt;
            r_out_coef  <= w_out_coef_nxt;
        end
    end

    assign B_ready   = r_b_ready;
    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_coef  = r_out_coef;
    assign out_last  = r_out_last;
    assign err       = r_err;

endmodule

// File: tb/tb_public_private_acc.sv
// Scoreboard bench for public_private_acc with DEPTH=16, BEATS=2.
module tb_public_private_acc;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned BEATS = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        B_valid;
    logic [41:0] B_out;
    logic [9:0]  idx_B;
    logic        B_ready;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_idx;
    logic [5:0]  out_coef;
    logic        out_last;
    logic        err;

    public_private_acc #(
        .DEPTH (DEPTH),
        .BEATS (BEATS)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .B_valid   (B_valid),
        .B_out     (B_out),
        .idx_B     (idx_B),
        .B_ready   (B_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_coef  (out_coef),
        .out_last  (out_last),
        .err       (err)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int idx;
        int coef;
        int last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_frame(input logic [5:0] e [DEPTH]);
        for (int i = 0; i < int'(DEPTH); i++) begin
            exp_t x;
            x.idx  = i;
            x.coef = int'(e[i]);
            x.last = (i == int'(DEPTH) - 1) ? 1 : 0;
            exp_q.push_back(x);
        end
    endtask

    task automatic send_beat(input int idx, input logic [5:0] ln [7]);
        int n;
        n       = 0;
        B_valid = 1'b1;
        idx_B   = 10'(idx);
        for (int k = 0; k < 7; k++) B_out[6*k +: 6] = ln[k];
        while (!B_ready && n < 200) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        if (n >= 200) chk("beat_accept_timeout", 0, 1);
        @(posedge clk_in);
        #1;
        B_valid = 1'b0;
    endtask

    task automatic run_drain(input bit tog);
        bit [3:0] pat;
        int       n;
        pat = 4'b1001;
        n   = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk_in);
            #1;
            if (tog) out_ready = pat[n % 4];
            n++;
        end
        chk("drain_complete", exp_q.size(), 0);
        exp_q.delete();
        out_ready = 1'b1;
        chk("b_ready_after_drain", int'(B_ready), 1);
        chk("out_valid_after_drain", int'(out_valid), 0);
    endtask

    // Monitor: pops on each transfer, checks stability while stalled.
    bit prev_stall = 1'b0;
    int prev_idx;
    int prev_coef;

    always @(negedge clk_in) begin
        if (!rst_in) begin
            prev_stall = 1'b0;
        end else if (out_valid) begin
            chk("b_ready_low_in_drain", int'(B_ready), 0);
            if (prev_stall) begin
                chk("hold_idx", int'(out_idx), prev_idx);
                chk("hold_coef", int'(out_coef), prev_coef);
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", int'(out_idx), -1);
                end else begin
                    exp_t x;
                    x = exp_q.pop_front();
                    chk("out_idx", int'(out_idx), x.idx);
                    chk("out_coef", int'(out_coef), x.coef);
                    chk("out_last", int'(out_last), x.last);
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev_idx   = int'(out_idx);
                prev_coef  = int'(out_coef);
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        logic [5:0] e  [DEPTH];
        logic [5:0] ln [7];
        logic [5:0] z  [7];

        z         = '{default: 6'd0};
        B_valid   = 1'b0;
        B_out     = '0;
        idx_B     = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_b_ready", int'(B_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_coef", int'(out_coef), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_err", int'(err), 0);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Frame A: lanes 1..7 at idx 0.
        e  = '{1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ln = '{1, 2, 3, 4, 5, 6, 7};
        push_frame(e);
        send_beat(0, ln);
        chk("b_ready_between_beats", int'(B_ready), 1);
        chk("no_valid_mid_frame", int'(out_valid), 0);
        send_beat(0, z);
        chk("valid_after_final_beat", int'(out_valid), 1);
        run_drain(1'b0);

        // Frame B: all-ones lanes at idx 12 wrap into positions 0..2.
`ifdef PP_ACC_NEGACYCLIC_EN
        e  = '{63, 63, 63, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
`else
        e  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
`endif
        ln = '{1, 1, 1, 1, 1, 1, 1};
        push_frame(e);
        send_beat(12, ln);
        send_beat(0, z);
        run_drain(1'b0);

        // Frame C: 40 + 40 wraps to 16.
        e  = '{16, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ln = '{40, 0, 0, 0, 0, 0, 0};
        push_frame(e);
        send_beat(0, ln);
        send_beat(0, ln);
        run_drain(1'b0);

        // Frame D: out-of-range index sets err and leaves the buffer alone.
        chk("err_before_bad_idx", int'(err), 0);
        e  = '{default: 6'd0};
        ln = '{1, 2, 3, 4, 5, 6, 7};
        push_frame(e);
        send_beat(16, ln);
        send_beat(0, z);
        run_drain(1'b0);
        chk("err_after_bad_idx", int'(err), 1);

        // Frame E: backpressure pattern 1,0,0,1 during the drain.
        e  = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0};
        push_frame(e);
        send_beat(3, ln);
        send_beat(0, z);
        run_drain(1'b1);
        chk("err_sticky", int'(err), 1);

        // Frame G: reset in the middle of the drain.
        e  = '{0, 0, 0, 0, 0, 9, 9, 9, 9, 9, 9, 9, 0, 0, 0, 0};
        ln = '{9, 9, 9, 9, 9, 9, 9};
        push_frame(e);
        send_beat(5, ln);
        send_beat(0, z);
        repeat (7) begin
            @(posedge clk_in);
            #1;
        end
        rst_in = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_b_ready", int'(B_ready), 1);
        chk("midrst_out_idx", int'(out_idx), 0);
        chk("midrst_out_coef", int'(out_coef), 0);
        chk("midrst_err", int'(err), 0);
        exp_q.delete();
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Frame F: clean frame after the aborted one.
        e  = '{1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        ln = '{1, 2, 3, 4, 5, 6, 7};
        push_frame(e);
        send_beat(0, ln);
        send_beat(0, z);
        run_drain(1'b0);

        repeat (2) @(posedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
